mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port word memory.
// Each access runs IDLE -> ACCESS -> DONE; the request is latched at the IDLE capture edge.
module mem_port_arbiter #(
  parameter int DBITS = 16,
  parameter int ABITS = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic             we0,
  input  logic             we1,
  input  logic [DBITS-1:0] addr0,
  input  logic [DBITS-1:0] addr1,
  input  logic [DBITS-1:0] wdata0,
  input  logic [DBITS-1:0] wdata1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             ack0,
  output logic             ack1,
  output logic [DBITS-1:0] rdata,
  output logic             busy,
  output logic [ABITS-1:0] mem_addr,
  output logic [DBITS-1:0] mem_din,
  output logic             mem_we,
  input  logic [DBITS-1:0] mem_dout
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t           state_q, state_d;
  logic [DBITS-1:0] mar_q, mar_d;
  logic [DBITS-1:0] wdr_q, wdr_d;
  logic [DBITS-1:0] rdata_q, rdata_d;
  logic             we_r_q, we_r_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic             ack0_q, ack0_d, ack1_q, ack1_d;
  logic             busy_q, busy_d;
  logic             en;
  logic             winner;
  logic             unused_mar_lsb;

  assign en             = (mar_q[DBITS-1:ABITS+1] == '0);
  assign unused_mar_lsb = mar_q[0];

  // Requester 1 wins when alone, or on a tie when requester 0 was served last.
  assign winner = req1 & (~req0 | ~last_q);

  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    wdr_d   = wdr_q;
    we_r_d  = we_r_q;
    owner_d = owner_q;
    last_d  = last_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          state_d = ACCESS;
          owner_d = winner;
          last_d  = winner;
          mar_d   = winner ? addr1  : addr0;
          wdr_d   = winner ? wdata1 : wdata0;
          we_r_d  = winner ? we1    : we0;
        end
      end
      ACCESS: begin
        state_d = DONE;
        if (we_r_q)  rdata_d = wdr_q;
        else if (en) rdata_d = mem_dout;
        else         rdata_d = DBITS'(16'hDEAD);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    gnt0_d = (state_d != IDLE) && !owner_d;
    gnt1_d = (state_d != IDLE) &&  owner_d;
    ack0_d = (state_d == DONE) && !owner_d;
    ack1_d = (state_d == DONE) &&  owner_d;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mar_q   <= '0;
      wdr_q   <= '0;
      we_r_q  <= 1'b0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      rdata_q <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      wdr_q   <= wdr_d;
      we_r_q  <= we_r_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      rdata_q <= rdata_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      busy_q  <= busy_d;
    end
  end

  // Reset gates the strobe directly so an aborted access never reaches memory.
  assign mem_we   = (state_q == ACCESS) && we_r_q && en && !reset;
  assign mem_addr = mar_q[ABITS:1];
  assign mem_din  = wdr_q;
  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign busy     = busy_q;
  assign rdata    = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand-written corner sequences,
// then random traffic checked against a transaction-timeline model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, ack0, ack1, busy, mem_we;
  logic [15:0] rdata, mem_din, mem_dout;
  logic [11:0] mem_addr;

  logic [15:0] mem     [4096];
  logic [15:0] mdl_mem [4096];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DBITS(16), .ABITS(12)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
    .rdata(rdata), .busy(busy),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
  );

  assign mem_dout = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_din;

  typedef struct {
    logic        r0, r1, w0, w1;
    logic [15:0] a0, a1, d0, d1;
    logic        win;
    logic [15:0] rd;
    logic        wpulse;
    logic [11:0] maddr;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (2) step();
    reset = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 7))
      0:       return 16'h4000 | 16'($urandom_range(0, 255));
      1:       return ($urandom_range(0, 1) == 0) ? 16'h1FFE : 16'h2000;
      default: return 16'($urandom_range(0, 127));
    endcase
  endfunction

  // Random-phase model state: the most recent capture and what it must produce.
  int          cap;
  logic        cown, cpulse, mlast, w;
  logic [15:0] crd, cdin, ca, cd;
  logic [11:0] cmaddr;
  logic        cwe;
  logic        acc, dn;
  logic [15:0] pre;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;

    vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 16'h0000, 1'b0, 16'hBEEF, 1'b1, 12'h008};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'hBEEF, 1'b0, 12'h008};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h4000, 16'h0000, 16'h0000, 1'b1, 16'hDEAD, 1'b0, 12'h000};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h4000, 16'h0000, 16'h1234, 1'b1, 16'h1234, 1'b0, 12'h000};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0020, 16'h0010, 16'hA5A5, 16'h0000, 1'b0, 16'hA5A5, 1'b1, 12'h010};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0020, 16'h0030, 16'h0000, 16'h7777, 1'b1, 16'h7777, 1'b1, 12'h018};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0030, 16'h0020, 16'h0000, 16'h0000, 1'b0, 16'h7777, 1'b0, 12'h018};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0021, 16'h0000, 16'h0000, 1'b1, 16'hA5A5, 1'b0, 12'h010};

    do_reset();
    check("rst_gnt0", gnt0, 0);  check("rst_gnt1", gnt1, 0);
    check("rst_ack0", ack0, 0);  check("rst_ack1", ack1, 0);
    check("rst_busy", busy, 0);  check("rst_mem_we", mem_we, 0);
    check("rst_rdata", rdata, 0); check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_din", mem_din, 0);

    // Directed table: one access per vector, back to back every 3 cycles.
    for (int v = 0; v < 8; v++) begin
      step();
      req0 = vecs[v].r0; req1 = vecs[v].r1; we0 = vecs[v].w0; we1 = vecs[v].w1;
      addr0 = vecs[v].a0; addr1 = vecs[v].a1; wdata0 = vecs[v].d0; wdata1 = vecs[v].d1;
      @(negedge clk);
      check("vec_idle_busy", busy, 0);
      step();
      @(negedge clk);
      check("vec_gnt0", gnt0, !vecs[v].win);
      check("vec_gnt1", gnt1, vecs[v].win);
      check("vec_busy", busy, 1);
      check("vec_mem_we", mem_we, vecs[v].wpulse);
      check("vec_mem_addr", mem_addr, vecs[v].maddr);
      step();
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
      check("vec_ack0", ack0, !vecs[v].win);
      check("vec_ack1", ack1, vecs[v].win);
      check("vec_rdata", rdata, vecs[v].rd);
      check("vec_done_mem_we", mem_we, 0);
      $display("vec %0d: winner=%0d rdata=0x%04h", v, vecs[v].win, rdata);
    end

    // Address change after capture must not disturb the access in flight.
    step();
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0020;
    @(negedge clk);
    step();
    addr0 = 16'h0040;
    @(negedge clk);
    check("late_addr_mem_addr", mem_addr, 12'h010);
    step();
    req0 = 1'b0;
    @(negedge clk);
    check("late_addr_ack0", ack0, 1);
    check("late_addr_rdata", rdata, 16'hA5A5);
    $display("late-addr: rdata=0x%04h", rdata);

    // Reset during ACCESS of a write aborts it.
    pre = mem[2];
    step();
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0004; wdata0 = 16'h5555;
    @(negedge clk);
    step();
    reset = 1'b1; req0 = 1'b0;
    @(negedge clk);
    check("abort_mem_we", mem_we, 0);
    step();
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_ack0", ack0, 0);
    check("abort_gnt0", gnt0, 0);
    check("abort_mem_word", mem[2], pre);
    step();
    @(negedge clk);
    check("abort_ack0_later", ack0, 0);
    $display("abort: mem[2]=0x%04h", mem[2]);

    // Held tie out of reset: grants alternate 0,1,0,1 every 3 cycles.
    do_reset();
    step();
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 16'h0010; addr1 = 16'h0020;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clk);
      check("tie_gnt0", gnt0, (i % 2) == 0);
      check("tie_gnt1", gnt1, (i % 2) == 1);
      step();
      @(negedge clk);
      check("tie_ack0", ack0, (i % 2) == 0);
      check("tie_ack1", ack1, (i % 2) == 1);
      step();
      @(negedge clk);
      check("tie_idle_busy", busy, 0);
      $display("tie access %0d: gnt order ok for requester %0d", i, i % 2);
    end
    req0 = 1'b0;

    // Requester 1 alone, held across three back-to-back accesses.
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      check("solo_gnt1", gnt1, 1);
      check("solo_gnt0", gnt0, 0);
      step();
      @(negedge clk);
      check("solo_ack1", ack1, 1);
      step();
      @(negedge clk);
      check("solo_idle_busy", busy, 0);
      $display("solo access %0d: ack1 seen", i);
    end
    req1 = 1'b0;

    // Random traffic against a timeline model: a capture at cycle c gives ACCESS at c+1, DONE at c+2.
    do_reset();
    for (int i = 0; i < 4096; i++) mdl_mem[i] = mem[i];
    cap = -10; mlast = 1'b1; cown = 1'b0; cpulse = 1'b0; crd = '0; cdin = '0; cmaddr = '0;
    for (int c = 0; c < 900; c++) begin
      step();
      acc = (c == cap + 1);
      dn  = (c == cap + 2);
      req0 = ((acc || dn) && !cown) ? 1'b1 : ($urandom_range(0, 9) < 4);
      req1 = ((acc || dn) &&  cown) ? 1'b1 : ($urandom_range(0, 9) < 4);
      we0 = 1'($urandom_range(0, 1)); we1 = 1'($urandom_range(0, 1));
      addr0 = rand_addr(); addr1 = rand_addr();
      wdata0 = 16'($urandom); wdata1 = 16'($urandom);
      if (!acc && !dn && (req0 || req1)) begin
        w = (req0 && req1) ? !mlast : req1;
        mlast = w; cown = w; cap = c;
        ca  = w ? addr1 : addr0;
        cd  = w ? wdata1 : wdata0;
        cwe = w ? we1 : we0;
        cmaddr = 12'((ca / 2) % 4096);
        cdin = cd;
        cpulse = cwe && (ca < 16'h2000);
        if (cwe)                crd = cd;
        else if (ca < 16'h2000) crd = mdl_mem[ca / 2];
        else                    crd = 16'hDEAD;
        if (cpulse) mdl_mem[ca / 2] = cd;
        $display("rand capture c=%0d req=%0d we=%0d addr=0x%04h exp_rdata=0x%04h", c, w, cwe, ca, crd);
      end
      @(negedge clk);
      check("rand_gnt0", gnt0, (acc || dn) && !cown);
      check("rand_gnt1", gnt1, (acc || dn) &&  cown);
      check("rand_ack0", ack0, dn && !cown);
      check("rand_ack1", ack1, dn &&  cown);
      check("rand_busy", busy, acc || dn);
      check("rand_mem_we", mem_we, acc && cpulse);
      if (acc) check("rand_mem_addr", mem_addr, cmaddr);
      if (acc && cpulse) check("rand_mem_din", mem_din, cdin);
      if (dn) check("rand_rdata", rdata, crd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
